// File: rtl/clk_gate_ctrl.sv
// Enable sequencer for a latch-based clock-gate cell: wake settle, idle hysteresis, per-requester ack.
// Optional DFT override of CLK_EN via input TEST_EN when CLK_GATE_CTRL_TEST_EN is defined.
module clk_gate_ctrl #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               CLK,
    input  logic               RST,
`ifdef CLK_GATE_CTRL_TEST_EN
    input  logic               TEST_EN,
`endif
    input  logic [NUM_REQ-1:0] REQ,
    output logic [NUM_REQ-1:0] ACK,
    output logic               CLK_EN,
    output logic               GATE_ON
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = (WAKE_CYCLES == 0) ? '0 : CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = (IDLE_CYCLES == 0) ? '0 : CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_IDLE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               clk_en_q, clk_en_d;
    logic               gate_on_q, gate_on_d;
    logic               any_req;

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        any_req   = |REQ;

        case (state_q)
            S_OFF: begin
                if (any_req) begin
                    if (WAKE_CYCLES > 0) begin
                        state_d = S_WAKE;
                        cnt_d   = WAKE_LOAD;
                    end else begin
                        state_d = S_ON;
                    end
                end
            end
            S_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = S_ON;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ON: begin
                if (!any_req) begin
                    if (IDLE_CYCLES > 0) begin
                        state_d = S_IDLE;
                        cnt_d   = IDLE_LOAD;
                    end else begin
                        state_d = S_OFF;
                    end
                end
            end
            S_IDLE: begin
                // A returning request cancels the shutdown without another settle pass
                if (any_req) begin
                    state_d = S_ON;
                end else if (cnt_q == '0) begin
                    state_d = S_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
            end
        endcase

        ack_d     = (state_d == S_ON) ? REQ : '0;
        clk_en_d  = (state_d != S_OFF);
        gate_on_d = (state_d == S_ON) || (state_d == S_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            ack_q     <= '0;
            clk_en_q  <= 1'b0;
            gate_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            clk_en_q  <= clk_en_d;
            gate_on_q <= gate_on_d;
        end
    end

    assign ACK     = ack_q;
    assign GATE_ON = gate_on_q;

`ifdef CLK_GATE_CTRL_TEST_EN
    // Scan/DFT forces the gated domain to clock without disturbing the sequencer
    assign CLK_EN = clk_en_q | TEST_EN;
`else
    assign CLK_EN = clk_en_q;
`endif

endmodule
